// File: rtl/song_sequencer.sv
// song_sequencer: fetches note words from an external song ROM and plays each for its
// encoded duration, with pause, stop, loop and an end-of-song pulse.
module song_sequencer #(
    parameter int NUM_SONGS = 8,
    parameter int MAX_NOTES = 64,
    parameter int IDX_W     = 6,
    parameter int TICK_DIV  = 12_500_000,
    parameter int DUR_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       song_sel,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             loop_en,
    output logic [3:0]       rom_song,
    output logic [IDX_W-1:0] rom_idx,
    output logic             rom_rd,
    input  logic [DUR_W+5:0] rom_data,
    output logic [3:0]       note,
    output logic [1:0]       octave,
    output logic             note_valid,
    output logic             busy,
    output logic             done,
    output logic [3:0]       cur_song
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX_NOTES - 1);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, PAUSED} state_t;
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [PW-1:0]    pre;
    logic [DUR_W-1:0] dcnt;
    logic [3:0]       w_note;
    logic [1:0]       w_oct;
    logic [DUR_W-1:0] w_dur;
    logic             tick, step, eos, sel_ok;
    assign {w_note, w_oct, w_dur} = rom_data;
    assign rom_song = cur_song;
    assign rom_idx  = idx;
    assign busy     = state != IDLE;
    // step: move past the current word (filler seen, or note fully played)
    always_comb begin
        tick   = state == PLAY && pre == PMAX;
        step   = (state == WAIT && w_dur != '0 && w_note == 4'hF) || (tick && dcnt == DUR_W'(1));
        eos    = (state == WAIT && w_dur == '0) || (step && idx == LAST);
        sel_ok = song_sel != 4'd0 && 32'(song_sel) < NUM_SONGS;
    end
    always_ff @(posedge clk) begin
        if (rst || (stop && state != IDLE)) begin
            state      <= IDLE;
            idx        <= '0;
            pre        <= '0;
            dcnt       <= '0;
            cur_song   <= '0;
            note       <= '0;
            octave     <= '0;
            note_valid <= 1'b0;
            rom_rd     <= 1'b0;
            done       <= 1'b0;
        end else begin
            rom_rd <= 1'b0;
            done   <= 1'b0;
            if (eos) begin
                idx        <= '0;
                note_valid <= 1'b0;
                if (loop_en) begin
                    state  <= FETCH;
                    rom_rd <= 1'b1;
                end else begin
                    state    <= IDLE;
                    done     <= 1'b1;
                    cur_song <= '0;
                    note     <= '0;
                    octave   <= '0;
                end
            end else if (step) begin
                idx        <= idx + 1'b1;
                state      <= FETCH;
                rom_rd     <= 1'b1;
                note_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !stop && sel_ok) begin
                        state    <= FETCH;
                        cur_song <= song_sel;
                        idx      <= '0;
                        rom_rd   <= 1'b1;
                    end
                    FETCH: state <= WAIT;
                    WAIT: begin
                        note       <= w_note;
                        octave     <= w_oct;
                        dcnt       <= w_dur;
                        pre        <= '0;
                        note_valid <= 1'b1;
                        state      <= PLAY;
                    end
                    // the cycle in which pause is first seen still counts toward the note
                    PLAY: begin
                        pre <= tick ? '0 : pre + 1'b1;
                        if (tick) dcnt <= dcnt - 1'b1;
                        if (pause) begin
                            state      <= PAUSED;
                            note_valid <= 1'b0;
                        end
                    end
                    PAUSED: if (!pause) begin
                        state      <= PLAY;
                        note_valid <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: IDLE acceptance vectors, model-predicted playback traces and
// hand-written pause, loop, stop and reset sequences.
module tb_song_sequencer;
    localparam int NS = 8, MAXN = 64, TD = 2;
    logic       clk = 1'b0, rst = 1'b1;
    logic [3:0] song_sel = '0;
    logic       start = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [3:0] rom_song, note, cur_song;
    logic [5:0] rom_idx;
    logic       rom_rd, note_valid, busy, done;
    logic [1:0] octave;
    logic [9:0] rom_data = '0;
    logic [9:0] mem [NS][MAXN];
    int applied = 0, miscompares = 0;
    typedef struct packed {
        logic busy, nv, done, rd;
        logic [3:0] note;
        logic [1:0] oct;
        logic [5:0] ridx;
        logic [3:0] rsong, cur;
    } obs_t;
    typedef struct {
        logic [3:0] sel;
        logic st, sp, eb, erd;
        logic [3:0] ecur;
    } vec_t;
    obs_t exp_q[$];
    vec_t vt[8];

    song_sequencer #(.NUM_SONGS(NS), .MAX_NOTES(MAXN), .IDX_W(6), .TICK_DIV(TD), .DUR_W(4)) dut (
        .clk(clk), .rst(rst), .song_sel(song_sel), .start(start), .pause(pause), .stop(stop),
        .loop_en(loop_en), .rom_song(rom_song), .rom_idx(rom_idx), .rom_rd(rom_rd),
        .rom_data(rom_data), .note(note), .octave(octave), .note_valid(note_valid),
        .busy(busy), .done(done), .cur_song(cur_song)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rom_rd) rom_data <= mem[rom_song[2:0]][rom_idx];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t ob();
        return {busy, note_valid, done, rom_rd, note, octave, rom_idx, rom_song, cur_song};
    endfunction

    function automatic obs_t mk(logic b, logic nv, logic d, logic rd, logic [3:0] n,
                                logic [1:0] o, logic [5:0] ri, logic [3:0] rs, logic [3:0] cur);
        return {b, nv, d, rd, n, o, ri, rs, cur};
    endfunction

    function automatic obs_t masked(obs_t a, obs_t e);
        obs_t m = a;
        if (!e.nv) begin
            m.note = '0;
            m.oct  = '0;
        end
        if (!e.rd) begin
            m.ridx  = '0;
            m.rsong = '0;
        end
        return m;
    endfunction

    // Expected per-cycle trace from the cycle after the accepting edge through the done pulse.
    function automatic void build(int s);
        logic [3:0] n, cs;
        logic [1:0] o;
        logic [3:0] d;
        cs = 4'(s);
        exp_q.delete();
        for (int i = 0; i < MAXN; i++) begin
            {n, o, d} = mem[s][i];
            exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 6'(i), cs, cs));
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, cs));
            if (d == 0) break;
            if (n == 4'hF) continue;
            repeat (int'(d) * TD) exp_q.push_back(mk(1, 1, 0, 0, n, o, 0, 0, cs));
        end
        exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    endfunction

    task automatic run_song(int s);
        obs_t e;
        build(s);
        song_sel = 4'(s);
        start = 1'b1;
        step();
        start = 1'b0;
        song_sel = 4'($urandom_range(1, 7));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("song%0d_trace", s), masked(ob(), e), e);
            if (exp_q.size() > 0) step();
        end
        step();
    endtask

    task automatic fill_random(int s);
        int len;
        len = $urandom_range(1, 8);
        for (int i = 0; i < MAXN; i++) begin
            if (i < len)
                mem[s][i] = {($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
                             2'($urandom_range(0, 2)), 4'($urandom_range(1, 3))};
            else if (i == len)
                mem[s][i] = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'd0};
            else
                mem[s][i] = '0;
        end
    endtask

    initial begin
        int hi, first, last, pcnt, nrd, ndone;
        logic seen_done;
        logic [5:0] rd_seq [4];
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < MAXN; i++) mem[s][i] = '0;
        mem[1][0] = {4'd2, 2'b00, 4'd3};
        mem[1][1] = {4'd3, 2'b00, 4'd5};
        mem[1][2] = {4'd9, 2'b10, 4'd0};
        mem[2][0] = {4'hF, 2'b00, 4'd1};
        mem[2][1] = {4'hF, 2'b00, 4'd1};
        mem[2][2] = {4'd5, 2'b01, 4'd1};
        mem[2][3] = {4'd0, 2'b00, 4'd0};
        for (int i = 0; i < MAXN; i++)
            mem[7][i] = {4'($urandom_range(0, 14)), 2'($urandom_range(0, 2)), 4'($urandom_range(1, 2))};
        vt = '{
            '{4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0},
            '{4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0},
            '{4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0},
            '{4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0},
            '{4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0},
            '{4'd1,  1'b1, 1'b0, 1'b1, 1'b1, 4'd1},
            '{4'd7,  1'b1, 1'b0, 1'b1, 1'b1, 4'd7},
            '{4'd7,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0}
        };
        step();
        step();
        chk("reset_state", ob(), '0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            song_sel = vt[i].sel;
            start = vt[i].st;
            stop = vt[i].sp;
            step();
            start = 1'b0;
            stop = 1'b0;
            chk($sformatf("idle_vec%0d", i), {busy, rom_rd, cur_song}, {vt[i].eb, vt[i].erd, vt[i].ecur});
            if (vt[i].eb) begin
                stop = 1'b1;
                step();
                stop = 1'b0;
                step();
            end
        end
        run_song(1);
        run_song(2);
        for (int k = 0; k < 10; k++) begin
            int s;
            s = $urandom_range(3, 6);
            fill_random(s);
            run_song(s);
        end
        run_song(7);
        // pause for 5 cycles once 3 cycles of a dur=4 note have sounded
        mem[4][0] = {4'd4, 2'b10, 4'd4};
        mem[4][1] = '0;
        song_sel = 4'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        hi = 0; first = -1; last = -1; pcnt = 0; seen_done = 1'b0;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            if (note_valid) begin
                hi++;
                if (first < 0) first = c;
                last = c;
            end
            if (done) seen_done = 1'b1;
            if (hi == 3 && pcnt == 0) begin
                pause = 1'b1;
                pcnt = 1;
            end else if (pcnt > 0 && pcnt < 5) pcnt++;
            else if (pcnt == 5) begin
                pause = 1'b0;
                pcnt = 6;
            end
            step();
        end
        pause = 1'b0;
        chk("pause_done_seen", 32'(seen_done), 1);
        chk("pause_hi_cycles", hi, 8);
        chk("pause_span", last - first + 1, 13);
        // loop: the end marker at index 2 restarts at index 0 without done
        loop_en = 1'b1;
        song_sel = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        nrd = 0; ndone = 0;
        for (int i = 0; i < 4; i++) rd_seq[i] = 6'h3F;
        for (int c = 0; c < 200 && nrd < 4; c++) begin
            if (done) ndone++;
            if (rom_rd) begin
                rd_seq[nrd] = rom_idx;
                nrd++;
            end
            if (nrd < 4) step();
        end
        chk("loop_rd_idx", {rd_seq[0], rd_seq[1], rd_seq[2], rd_seq[3]}, {6'd0, 6'd1, 6'd2, 6'd0});
        chk("loop_no_done", ndone, 0);
        for (int c = 0; c < 20 && !note_valid; c++) step();
        chk("loop_replay", {note_valid, note, cur_song}, {1'b1, 4'd2, 4'd1});
        stop = 1'b1;
        step();
        stop = 1'b0;
        loop_en = 1'b0;
        chk("stop_clear", ob(), '0);
        step();
        chk("stop_stays_idle", {busy, done}, 2'b00);
        // reset in the middle of a note
        song_sel = 4'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && !note_valid; c++) step();
        chk("pre_rst_playing", {busy, note_valid}, 2'b11);
        rst = 1'b1;
        step();
        chk("rst_mid_note", ob(), '0);
        rst = 1'b0;
        step();
        chk("after_rst_idle", ob(), '0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
